// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter: a one-hot token marks the highest-priority requester.
// Each grant is held until release, request drop, or hold expiry, followed by one dead cycle.
module ring_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] req_i,
   input  logic             release_i,
   output logic [WIDTH-1:0] grant_o,
   output logic             grant_valid_o,
   output logic [WIDTH-1:0] token_o,
   output logic             timeout_o
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [HW-1:0]    HOLD_ONE = HW'(1);
   localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OWNED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] token_q, token_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             timeout_q, timeout_d;

   logic [WIDTH-1:0] reqUpper;
   logic [WIDTH-1:0] pickSrc;
   logic [WIDTH-1:0] pick;
   logic [WIDTH-1:0] tokenRot;
   logic             ownerDone;
   logic             holdExpired;

   // Requests at or above the token win; otherwise the scan wraps to the lowest set bit overall.
   always_comb begin
      reqUpper = req_i & ~(token_q - ONE);
      pickSrc  = (reqUpper != '0) ? reqUpper : req_i;
      pick     = pickSrc & (~pickSrc + ONE);
   end

   assign tokenRot    = (grant_q << 1) | (grant_q >> (WIDTH - 1));
   assign ownerDone   = release_i | ((req_i & grant_q) == '0);
   assign holdExpired = (hold_q == HOLD_MAX);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      token_d   = token_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i != '0) begin
               grant_d = pick;
               hold_d  = HOLD_ONE;
               state_d = OWNED;
            end
         end
         default: begin
            // A release landing on the expiry edge counts as a normal release, so no timeout.
            if (ownerDone || holdExpired) begin
               grant_d   = '0;
               token_d   = tokenRot;
               hold_d    = '0;
               state_d   = IDLE;
               timeout_d = holdExpired && !ownerDone;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         token_q   <= ONE;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         token_q   <= token_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = |grant_q;
   assign token_o       = token_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter (WIDTH=4, MAX_HOLD=8): reset, fairness, timeout, wrap,
// simultaneous release/expiry, non-preemption and mid-grant reset.
module tb_ring_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       rel;
   logic [3:0] grant;
   logic       grantValid;
   logic [3:0] token;
   logic       timeout;

   int checkCount = 0;
   int passCount  = 0;

   ring_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_i         (req),
      .release_i     (rel),
      .grant_o       (grant),
      .grant_valid_o (grantValid),
      .token_o       (token),
      .timeout_o     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
   endtask

   task automatic checkState(input string tag, input logic [3:0] expGrant, input logic [3:0] expToken,
                             input logic expTimeout);
      checkOutput({tag, ".grant"},   32'(grant),      32'(expGrant));
      checkOutput({tag, ".valid"},   32'(grantValid), 32'(|expGrant));
      checkOutput({tag, ".token"},   32'(token),      32'(expToken));
      checkOutput({tag, ".timeout"}, 32'(timeout),    32'(expTimeout));
   endtask

   // Drive inputs at a falling edge, then wait until the next falling edge to observe.
   task automatic applyStimulus(input logic [3:0] r, input logic rl);
      req = r;
      rel = rl;
      @(negedge clk);
   endtask

   logic [3:0] fairGrant [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
   logic [3:0] fairToken [9] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                 4'b1000, 4'b1000, 4'b0001, 4'b0001};

   initial begin
      reset = 1'b0;
      req   = 4'b0000;
      rel   = 1'b0;
      #2 reset = 1'b1;
      #1 checkState("por", 4'b0000, 4'b0001, 1'b0);

      @(negedge clk);
      reset = 1'b0;
      applyStimulus(4'b1111, 1'b0);
      checkState("first", 4'b0001, 4'b0001, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 checkState("rst50", 4'b0000, 4'b0001, 1'b0);

      @(negedge clk);
      reset = 1'b0;
      req   = 4'b1111;
      rel   = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checkState($sformatf("fair%0d", i), fairGrant[i], fairToken[i], 1'b0);
      end
      applyStimulus(4'b0000, 1'b1);
      checkState("drain", 4'b0000, 4'b0010, 1'b0);

      reset = 1'b1;
      #1 reset = 1'b0;
      applyStimulus(4'b0100, 1'b0);
      checkState("hold1", 4'b0100, 4'b0001, 1'b0);
      for (int i = 2; i <= 8; i++) begin
         @(negedge clk);
         checkState($sformatf("hold%0d", i), 4'b0100, 4'b0001, 1'b0);
      end
      @(negedge clk);
      checkState("expire", 4'b0000, 4'b1000, 1'b1);
      @(negedge clk);
      checkState("regrant", 4'b0100, 4'b1000, 1'b0);

      for (int i = 2; i <= 8; i++) begin
         @(negedge clk);
         checkState($sformatf("again%0d", i), 4'b0100, 4'b1000, 1'b0);
      end
      applyStimulus(4'b0100, 1'b1);
      checkState("simul", 4'b0000, 4'b1000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkState("idle", 4'b0000, 4'b1000, 1'b0);

      applyStimulus(4'b0011, 1'b0);
      checkState("wrap", 4'b0001, 4'b1000, 1'b0);
      applyStimulus(4'b0010, 1'b0);
      checkState("drop", 4'b0000, 4'b0010, 1'b0);
      @(negedge clk);
      checkState("own1", 4'b0010, 4'b0010, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      checkState("nopreempt", 4'b0010, 4'b0010, 1'b0);

      reset = 1'b1;
      #1 checkState("midrst", 4'b0000, 4'b0001, 1'b0);
      #1 reset = 1'b0;
      @(negedge clk);
      checkState("restart", 4'b0001, 4'b0001, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of requesters and ring width.
REQ-002 SHALL provide parameter MAX_HOLD, default 8: maximum cycles one grant is held (legal range 1..255).
REQ-003 SHALL provide port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL provide port req  input  WIDTH: request lines; bit i = requester i.
REQ-006 SHALL provide port release  input  1: current owner done; sampled only while a grant is active.
REQ-007 SHALL provide port grant  output  WIDTH: registered grant; one-hot or all-zero.
REQ-008 SHALL provide port grant_valid  output  1: high when grant is non-zero.
REQ-009 SHALL provide port token  output  WIDTH: registered one-hot ring pointer marking the highest-priority position.
REQ-010 SHALL provide port timeout  output  1: registered one-cycle pulse flagging forced release on hold expiry.

Function
REQ-011 SHALL implement two states: IDLE (no grant) and OWNED (one grant active).
REQ-012 IDLE, req==0 at an edge: stay IDLE; token and grant unchanged.
REQ-013 IDLE, req!=0 at an edge: grant <= the first set req bit scanning circularly from the token position upward, wrapping MSB->LSB; go to OWNED; latency = 1 edge.
REQ-014 OWNED: hold counter = 1 in the first granted cycle and increments each cycle; width ceil(log2(MAX_HOLD+1)) bits.
REQ-015 OWNED exit at an edge when any holds: release=1, req[owner]=0, or hold counter==MAX_HOLD; the grant therefore lasts at most MAX_HOLD cycles.
REQ-016 On exit: grant <= 0, state <= IDLE, token <= rotate-left of the exiting grant (bit WIDTH-1 wraps to bit 0).
REQ-017 Every exit SHALL insert exactly one dead cycle (grant==0) before the next grant, including back-to-back requests.
REQ-018 timeout SHALL be 1 only in the dead cycle following an exit caused solely by hold expiry; otherwise 0.
REQ-019 release=1 or req[owner]=0 in the same edge as hold expiry: treated as a normal release; timeout stays 0.
REQ-020 No preemption: changes on non-owner req bits while OWNED SHALL be ignored.
REQ-021 release while IDLE SHALL be ignored.
REQ-022 grant_valid SHALL equal OR-reduction of grant at all times.
REQ-023 WIDTH=1 SHALL work: token constant 1; grant follows REQ-013..REQ-017.

Reset
REQ-024 reset=1 SHALL force, without waiting for a clock edge: state IDLE, grant=0, grant_valid=0, timeout=0, token=1 (bit 0 only), hold counter=0.
REQ-025 reset asserted mid-grant SHALL drop the grant immediately with no timeout pulse; after deassertion arbitration restarts from token=1.
REQ-026 The first arbitration SHALL occur on the first rising edge with reset low.

Verification
REQ-027 Reset: assert reset at t=50 with req=1111 -> grant=0000, grant_valid=0, token=0001, timeout=0 within the same timestep.
REQ-028 Fairness: req=1111 held, release pulsed in each granted cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; token 0010,0100,1000,0001.
REQ-029 Timeout: MAX_HOLD=8, req=0100 held, release=0 -> grant=0100 for 8 cycles, then dead cycle with timeout=1 and token=1000, then grant=0100 again.
REQ-030 Wrap: token=1000, req=0011 -> next grant=0001, then token=0010.
REQ-031 Simultaneous: release=1 on the 8th held cycle -> dead cycle with timeout=0.
REQ-032 Mid-grant reset: grant=0010 active, reset pulsed between edges -> grant=0000 and token=0001 before the next edge.
